gather_vec: RTL and testbench

Parametrised successor of the tile-side gather stage. It collects a stream of channel words (LANES words per beat) in the clk_tl domain and assembles them into one MAX_CH-wide channel vector for the tile datapath. The channel count is set at run time, and unused channels are forced to zero. Assembly and output are double-buffered, so back-to-back vectors flow without bubbles. Framing errors are detected through in_last. The block sits directly after the network-to-tile CDC FIFO; it contains no CDC.

---
 rtl/gather_vec.sv | 131 +++++++++++++
 tb/tb_gather_vec.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gather_vec.sv
// gather_vec: assembles LANES-wide channel beats into one MAX_CH-wide vector.
// Assembly and output buffers are separate, so back-to-back vectors flow without bubbles.
module gather_vec #(
  parameter int DW     = 8,
  parameter int MAX_CH = 128,
  parameter int LANES  = 1,
  parameter int CW     = $clog2(MAX_CH + 1)
) (
  input  logic                 clk_tl,
  input  logic                 rstn_tl,
  input  logic [CW-1:0]        cfg_chans,
  input  logic [LANES*DW-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [MAX_CH*DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_short,
  output logic                 err_long,
  output logic [15:0]          vec_cnt
);

  localparam int NBEAT = MAX_CH / LANES;
  localparam int KW    = $clog2(NBEAT + 1);

  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        act_q, act_d;
  logic                 asm_full_q, asm_full_d;
  logic [MAX_CH*DW-1:0] asm_q, asm_d;
  logic [MAX_CH*DW-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;
  logic [15:0]          vec_cnt_q, vec_cnt_d;

  logic [CW-1:0] eff_c, cur_c;
  int            beats, lim;
  logic          beat_acc, last_beat, complete, consume, out_free;

  // NOTE: every variable gets a default at the top of each always_comb, so no path can infer a latch.
  always_comb begin
    eff_c = cfg_chans;
    if (cfg_chans == '0 || int'(cfg_chans) > MAX_CH) eff_c = CW'(MAX_CH);
    // Beat 0 uses the live configuration; later beats use the value captured at beat 0.
    cur_c     = (k_q == '0) ? eff_c : act_q;
    beats     = (int'(cur_c) + LANES - 1) / LANES;
    lim       = (int'(k_q) + 1) * LANES;
    if (int'(cur_c) < lim) lim = int'(cur_c);
    beat_acc  = in_valid & ~asm_full_q;
    last_beat = (int'(k_q) == beats - 1);
    complete  = beat_acc & (last_beat | in_last);
    consume   = out_valid_q & out_ready;
    out_free  = ~out_valid_q | out_ready;
  end

  // Write the accepted beat into its slots; on completion clear everything at or beyond the limit.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < MAX_CH; i++) begin
      if (beat_acc && (i / LANES) == int'(k_q))
        asm_d[i*DW +: DW] = in_data[(i % LANES)*DW +: DW];
      if (complete && i >= lim)
        asm_d[i*DW +: DW] = '0;
    end
  end

  always_comb begin
    k_d         = k_q;
    act_d       = act_q;
    asm_full_d  = asm_full_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    vec_cnt_d   = vec_cnt_q + 16'(consume);

    if (beat_acc) begin
      if (k_q == '0) act_d = eff_c;
      k_d         = complete ? '0 : k_q + KW'(1);
      err_short_d = complete & in_last & ~last_beat;
      err_long_d  = complete & last_beat & ~in_last;
    end

    if (asm_full_q && consume) begin
      out_d      = asm_q;
      asm_full_d = 1'b0;
    end else if (complete && out_free) begin
      out_d       = asm_d;
      out_valid_d = 1'b1;
    end else if (complete) begin
      asm_full_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      k_q         <= '0;
      act_q       <= CW'(MAX_CH);
      asm_full_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      vec_cnt_q   <= '0;
    end else begin
      k_q         <= k_d;
      act_q       <= act_d;
      asm_full_q  <= asm_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      vec_cnt_q   <= vec_cnt_d;
    end
  end

  // NOTE: the assembly buffer has no reset; each vector is masked on completion, so stale words never reach out_data.
  always_ff @(posedge clk_tl) asm_q <= asm_d;

  assign in_ready  = ~asm_full_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_gather_vec.sv
// Bench for gather_vec: two instances (LANES=1 and LANES=4) checked against a
// vector-level reference model, with directed cases followed by randomized traffic.
module tb_gather_vec;

  localparam int DW     = 8;
  localparam int MAX_CH = 128;
  localparam int CW     = $clog2(MAX_CH + 1);
  localparam int VW     = MAX_CH * DW;
  localparam int TMO    = 3000;

  logic          clk_tl    = 1'b0;
  logic          rstn_tl   = 1'b1;
  logic [CW-1:0] cfg_chans = '0;
  logic          dir_ready = 1'b1;
  logic          rnd_ready = 1'b1;
  logic          rnd_rdy   = 1'b0;
  logic          out_ready;

  logic [DW-1:0] a_in_data = '0;
  logic          a_in_valid = 1'b0, a_in_last = 1'b0;
  logic          a_in_ready, a_out_valid, a_err_short, a_err_long;
  logic [VW-1:0] a_out_data;
  logic [15:0]   a_vec_cnt;

  logic [31:0]   b_in_data = '0;
  logic          b_in_valid = 1'b0, b_in_last = 1'b0;
  logic          b_in_ready, b_out_valid, b_err_short, b_err_long;
  logic [VW-1:0] b_out_data;
  logic [15:0]   b_vec_cnt;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  // Reference model state, per instance (0: LANES=1, 1: LANES=4).
  int            m_k[2], m_c[2], m_pushed[2], exp_short[2], exp_long[2];
  logic [DW-1:0] m_vec[2][MAX_CH];
  logic [VW-1:0] exp_a[$], exp_b[$];
  int            got_a = 0, got_b = 0;
  int            seen_short[2], seen_long[2];

  assign out_ready = rnd_rdy ? rnd_ready : dir_ready;

  always #5 clk_tl = ~clk_tl;
  always @(posedge clk_tl) cyc++;

  gather_vec #(.DW(DW), .MAX_CH(MAX_CH), .LANES(1)) u_a (
    .clk_tl(clk_tl), .rstn_tl(rstn_tl), .cfg_chans(cfg_chans),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .err_short(a_err_short), .err_long(a_err_long), .vec_cnt(a_vec_cnt)
  );

  gather_vec #(.DW(DW), .MAX_CH(MAX_CH), .LANES(4)) u_b (
    .clk_tl(clk_tl), .rstn_tl(rstn_tl), .cfg_chans(cfg_chans),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .err_short(b_err_short), .err_long(b_err_long), .vec_cnt(b_vec_cnt)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rdy(input int d);
    return (d == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic int pending(input int d);
    return (d == 0) ? (exp_a.size() - got_a) : (exp_b.size() - got_b);
  endfunction

  function automatic logic [15:0] vcnt(input int d);
    return (d == 0) ? a_vec_cnt : b_vec_cnt;
  endfunction

  // Vector-level model: start each vector all-zero, fill active channels, emit on completion.
  task automatic model_beat(input int d, input logic [31:0] data, input bit last);
    int nl, c, nb, ch;
    logic [VW-1:0] v;
    nl = (d == 0) ? 1 : 4;
    if (m_k[d] == 0) begin
      m_c[d] = (cfg_chans == '0 || int'(cfg_chans) > MAX_CH) ? MAX_CH : int'(cfg_chans);
      for (int i = 0; i < MAX_CH; i++) m_vec[d][i] = '0;
    end
    c  = m_c[d];
    nb = (c + nl - 1) / nl;
    for (int l = 0; l < nl; l++) begin
      ch = m_k[d] * nl + l;
      if (ch < c) m_vec[d][ch] = data[l*DW +: DW];
    end
    if (last || m_k[d] == nb - 1) begin
      if (last && m_k[d] < nb - 1) exp_short[d]++;
      if (!last && m_k[d] == nb - 1) exp_long[d]++;
      for (int i = 0; i < MAX_CH; i++) v[i*DW +: DW] = m_vec[d][i];
      if (d == 0) exp_a.push_back(v); else exp_b.push_back(v);
      m_pushed[d]++;
      m_k[d] = 0;
    end else begin
      m_k[d]++;
    end
  endtask

  task automatic idle();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input int d, input logic [31:0] data, input bit last);
    int w = 0;
    if (d == 0) begin a_in_valid = 1'b1; a_in_data = data[DW-1:0]; a_in_last = last; end
    else begin b_in_valid = 1'b1; b_in_data = data; b_in_last = last; end
    while (!in_rdy(d) && w < TMO) begin @(posedge clk_tl); #1; w++; end
    check($sformatf("beat_accept[%0d]", d), in_rdy(d), 1'b1);
    @(posedge clk_tl);
    model_beat(d, data, last);
    #1;
  endtask

  task automatic drain(input int d);
    int w = 0;
    while (pending(d) != 0 && w < TMO) begin @(posedge clk_tl); #1; w++; end
    check($sformatf("drain[%0d]", d), pending(d), 0);
    repeat (2) @(posedge clk_tl);
    #1;
    check($sformatf("vec_cnt[%0d]", d), vcnt(d), m_pushed[d]);
    check($sformatf("short_cnt[%0d]", d), seen_short[d], exp_short[d]);
    check($sformatf("long_cnt[%0d]", d), seen_long[d], exp_long[d]);
  endtask

  task automatic do_reset(input bit chk);
    idle();
    rstn_tl = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_k[d] = 0; m_c[d] = MAX_CH; m_pushed[d] = 0; exp_short[d] = 0; exp_long[d] = 0;
    end
    exp_a.delete();
    exp_b.delete();
    #2;
    if (chk) begin
      check("rst_a_in_ready", a_in_ready, 1'b1);
      check("rst_a_out_valid", a_out_valid, 1'b0);
      check("rst_a_out_data", a_out_data, '0);
      check("rst_a_err_short", a_err_short, 1'b0);
      check("rst_a_err_long", a_err_long, 1'b0);
      check("rst_a_vec_cnt", a_vec_cnt, 16'd0);
      check("rst_b_in_ready", b_in_ready, 1'b1);
      check("rst_b_out_valid", b_out_valid, 1'b0);
      check("rst_b_out_data", b_out_data, '0);
      check("rst_b_err_short", b_err_short, 1'b0);
      check("rst_b_err_long", b_err_long, 1'b0);
      check("rst_b_vec_cnt", b_vec_cnt, 16'd0);
    end
    @(posedge clk_tl); #1;
    rstn_tl = 1'b1;
    @(posedge clk_tl); #1;
  endtask

  // Output monitor: every handshake must match the oldest outstanding model vector.
  always @(negedge clk_tl) begin
    if (!rstn_tl) begin
      got_a = 0; got_b = 0;
      for (int d = 0; d < 2; d++) begin seen_short[d] = 0; seen_long[d] = 0; end
    end else begin
      if (a_out_valid && out_ready) begin
        check("a_vec_expected", got_a < exp_a.size(), 1'b1);
        if (got_a < exp_a.size()) check("a_vec_data", a_out_data, exp_a[got_a]);
        got_a++;
      end
      if (b_out_valid && out_ready) begin
        check("b_vec_expected", got_b < exp_b.size(), 1'b1);
        if (got_b < exp_b.size()) check("b_vec_data", b_out_data, exp_b[got_b]);
        got_b++;
      end
      if (a_err_short) seen_short[0]++;
      if (a_err_long)  seen_long[0]++;
      if (b_err_short) seen_short[1]++;
      if (b_err_long)  seen_long[1]++;
    end
  end

  initial forever begin
    @(posedge clk_tl); #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, nb, mode, cut, eff, nl;
    #1;
    do_reset(1'b1);

    // Basic LANES=1 vector, latency and zero fill.
    cfg_chans = CW'(4);
    send_beat(0, 32'h11, 1'b0);
    send_beat(0, 32'h22, 1'b0);
    send_beat(0, 32'h33, 1'b0);
    check("t1_no_early_valid", a_out_valid, 1'b0);
    send_beat(0, 32'h44, 1'b1);
    idle();
    check("t1_latency", a_out_valid, 1'b1);
    check("t1_data", a_out_data, 32'h44332211);
    drain(0);

    // LANES=4, C=6: lanes beyond C discarded.
    cfg_chans = CW'(6);
    send_beat(1, 32'h04030201, 1'b0);
    send_beat(1, 32'h08070605, 1'b1);
    idle();
    check("t2_data", b_out_data, 48'h060504030201);
    check("t2_err_short", b_err_short, 1'b0);
    check("t2_err_long", b_err_long, 1'b0);
    drain(1);

    // Early in_last, then a fresh vector from channel 0.
    cfg_chans = CW'(8);
    send_beat(0, 32'hA0, 1'b0);
    send_beat(0, 32'hA1, 1'b0);
    send_beat(0, 32'hA2, 1'b1);
    idle();
    check("t3_err_short", a_err_short, 1'b1);
    check("t3_err_long", a_err_long, 1'b0);
    check("t3_data", a_out_data, 24'hA2A1A0);
    for (int i = 0; i < 8; i++) send_beat(0, 32'hB0 + i, i == 7);
    idle();
    check("t3_next_ch0", a_out_data[7:0], 8'hB0);
    drain(0);

    // Missing in_last on the final beat.
    do_reset(1'b0);
    cfg_chans = CW'(4);
    for (int i = 0; i < 4; i++) send_beat(0, 32'hC0 + i, 1'b0);
    idle();
    check("t4_err_long", a_err_long, 1'b1);
    check("t4_valid", a_out_valid, 1'b1);
    check("t4_data", a_out_data, 32'hC3C2C1C0);
    for (int i = 0; i < 4; i++) send_beat(0, 32'hD0 + i, i == 3);
    idle();
    drain(0);
    check("t4_vec_cnt", a_vec_cnt, 16'd2);

    // Backpressure: two vectors pending, then a single consume.
    do_reset(1'b0);
    dir_ready = 1'b0;
    cfg_chans = CW'(4);
    for (int i = 0; i < 4; i++) send_beat(0, 32'hE0 + i, i == 3);
    for (int i = 0; i < 4; i++) send_beat(0, 32'hF0 + i, i == 3);
    idle();
    check("t5_in_ready_low", a_in_ready, 1'b0);
    check("t5_hold_v1", a_out_data, 32'hE3E2E1E0);
    repeat (3) @(posedge clk_tl);
    #1;
    check("t5_stable_v1", a_out_data, 32'hE3E2E1E0);
    check("t5_stable_valid", a_out_valid, 1'b1);
    dir_ready = 1'b1;
    @(posedge clk_tl); #1;
    dir_ready = 1'b0;
    check("t5_v2", a_out_data, 32'hF3F2F1F0);
    check("t5_v2_valid", a_out_valid, 1'b1);
    check("t5_in_ready_back", a_in_ready, 1'b1);
    dir_ready = 1'b1;
    drain(0);

    // Reset mid-vector drops the partial vector.
    cfg_chans = CW'(4);
    send_beat(0, 32'h5A, 1'b0);
    send_beat(0, 32'h5B, 1'b0);
    idle();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) send_beat(0, 32'h60 + i, i == 3);
    idle();
    drain(0);
    check("t6_vec_cnt", a_vec_cnt, 16'd1);

    // Throughput: one vector per cycle for C=1, and per 32 cycles for LANES=4, C=128.
    cfg_chans = CW'(1);
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      send_beat(0, 32'h70 + i, 1'b1);
      check("t7_valid_no_gap", a_out_valid, 1'b1);
    end
    check("t7_a_cycles", cyc - t0, 6);
    idle();
    drain(0);
    cfg_chans = '0;
    t0 = cyc;
    for (int i = 0; i < 64; i++) send_beat(1, $urandom, (i % 32) == 31);
    check("t7_b_cycles", cyc - t0, 64);
    idle();
    drain(1);

    // Randomized traffic with random backpressure and framing errors.
    for (int d = 0; d < 2; d++) begin
      nl = (d == 0) ? 1 : 4;
      rnd_rdy = 1'b1;
      for (int n = 0; n < 25; n++) begin
        cfg_chans = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(1, 40));
        eff  = (cfg_chans == '0 || int'(cfg_chans) > MAX_CH) ? MAX_CH : int'(cfg_chans);
        nb   = (eff + nl - 1) / nl;
        mode = $urandom_range(0, 5);
        cut  = (mode == 0 && nb > 1) ? $urandom_range(0, nb - 2) : nb - 1;
        for (int k = 0; k <= cut; k++) begin
          send_beat(d, $urandom, (k == cut) && (mode != 1));
          if (k == 0) cfg_chans = CW'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 3) == 0) begin
          idle();
          repeat ($urandom_range(1, 3)) @(posedge clk_tl);
          #1;
        end
      end
      idle();
      rnd_rdy = 1'b0;
      dir_ready = 1'b1;
      drain(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
